// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers, InvShiftRows and the round-stage FSM encoding.
// Byte i of a state sits at bits [127-8i -: 8] and is row i%4, column i/4.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_NB      = 4;

    typedef logic [7:0]             aes_byte_t;
    typedef logic [31:0]            aes_col_t;
    typedef logic [AES_STATE_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        StIdle,
        StSub,
        StFin,
        StOut
    } aes_st_e;

    function automatic aes_byte_t gf_xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t acc;
        aes_byte_t p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    // out[r][c] = in[r][(c - r) mod 4]
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int r = 0; r < int'(AES_NB); r++) begin
            for (int c = 0; c < int'(AES_NB); c++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round_stage_mix.sv
// InvMixColumns on one 32-bit column (row 0 in the top byte), combinational.
module aes_inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    aes_byte_t b [4];

    always_comb begin
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            b[r] = col_i[31 - 8 * r -: 8];
        end
        for (int r = 0; r < 4; r++) begin
            col_o[31 - 8 * r -: 8] = gf_mul(8'h0e, b[r]) ^ gf_mul(8'h0b, b[(r + 1) % 4]) ^
                                     gf_mul(8'h0d, b[(r + 2) % 4]) ^ gf_mul(8'h09, b[(r + 3) % 4]);
        end
    end

endmodule

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, one byte, purely combinational table lookup.
module aes_inv_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    localparam logic [2047:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    assign data_o = InvSbox[2047 - 8 * int'(data_i) -: 8];

endmodule

// File: rtl/aes_inv_round_stage.sv
// Column-serial AES decryption round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// Define AES_INV_MIXCOL_EN to include InvMixColumns (skipped when last_round=1).
module aes_inv_round_stage
    import aes_pkg::*;
#(
    parameter int unsigned NB = AES_NB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    aes_st_e    st_q, st_d;
    logic [1:0] col_q, col_d;
    aes_state_t data_q, data_d;
    aes_state_t key_q, key_d;
    aes_state_t out_q, out_d;
    aes_col_t   sel_col, sub_col;
    aes_state_t add_key, fin_res;

    assign sel_col = data_q[32 * (NB - 1 - int'(col_q)) +: 32];

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .data_i(sel_col[31 - 8 * i -: 8]),
            .data_o(sub_col[31 - 8 * i -: 8])
        );
    end

    assign add_key = data_q ^ key_q;

`ifdef AES_INV_MIXCOL_EN
    logic       last_q, last_d;
    aes_state_t mixed;

    for (genvar i = 0; i < 4; i++) begin : g_mix
        aes_inv_mix_column u_mix (
            .col_i(add_key[32 * i +: 32]),
            .col_o(mixed[32 * i +: 32])
        );
    end

    assign fin_res = last_q ? add_key : mixed;
`else
    // Mixing happens outside this stage in this build, so last_round has no effect here.
    logic unused_last;
    assign unused_last = last_round;
    assign fin_res     = add_key;
`endif

    always_comb begin
        st_d   = st_q;
        col_d  = col_q;
        data_d = data_q;
        key_d  = key_q;
        out_d  = out_q;
`ifdef AES_INV_MIXCOL_EN
        last_d = last_q;
`endif
        unique case (st_q)
            StIdle: begin
                if (in_valid) begin
                    data_d = inv_shift_rows(state_in);
                    key_d  = key_in;
`ifdef AES_INV_MIXCOL_EN
                    last_d = last_round;
`endif
                    col_d  = 2'd0;
                    st_d   = StSub;
                end
            end
            StSub: begin
                data_d[32 * (NB - 1 - int'(col_q)) +: 32] = sub_col;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) st_d = StFin;
            end
            StFin: begin
                out_d = fin_res;
                st_d  = StOut;
            end
            StOut: begin
                if (out_ready) st_d = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= StIdle;
            col_q  <= 2'd0;
            data_q <= '0;
            key_q  <= '0;
            out_q  <= '0;
`ifdef AES_INV_MIXCOL_EN
            last_q <= 1'b0;
`endif
        end else begin
            st_q   <= st_d;
            col_q  <= col_d;
            data_q <= data_d;
            key_q  <= key_d;
            out_q  <= out_d;
`ifdef AES_INV_MIXCOL_EN
            last_q <= last_d;
`endif
        end
    end

    assign in_ready  = (st_q == StIdle);
    assign out_valid = (st_q == StOut);
    assign state_out = out_q;

endmodule

// File: tb/tb_aes_inv_round_stage.sv
// Bench for aes_inv_round_stage: GF(2^8)-derived reference model, queue scoreboard, literal vectors.
module tb_aes_inv_round_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] key_in;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    always #5 clk = ~clk;

    aes_inv_round_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .key_in    (key_in),
        .last_round(last_round),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int outs = 0;
    int prev_rise = -1;
    bit first_seen = 0;
    logic [7:0]   inv_tab [256];
    logic [127:0] exp_q [$];
    int           acc_q [$];

    localparam logic [127:0] V1_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] V1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        int r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((b >> i) & 1) r ^= a;
            a = a << 1;
            if (a & 'h100) a ^= 'h11b;
        end
        return r;
    endfunction

    function automatic int rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 'hff;
    endfunction

    // Forward S-box from multiplicative inverse + affine map, then inverted into inv_tab.
    task automatic build_table();
        for (int x = 0; x < 256; x++) begin
            int inv = 0;
            int s;
            for (int y = 1; y < 256 && x != 0; y++) begin
                if (gmul(x, y) == 1) inv = y;
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                           input logic l);
        int b [16];
        int t [16];
        logic [127:0] res;
        bit do_mix = 0;
`ifdef AES_INV_MIXCOL_EN
        do_mix = !l;
`endif
        for (int i = 0; i < 16; i++) b[i] = int'(s[127 - 8 * i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r + 4 * c] = int'(inv_tab[b[r + 4 * ((c - r + 4) % 4)]]) ^
                               int'(k[127 - 8 * (r + 4 * c) -: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                int v = t[4 * c + r];
                if (do_mix)
                    v = gmul('h0e, t[4 * c + r]) ^ gmul('h0b, t[4 * c + (r + 1) % 4]) ^
                        gmul('h0d, t[4 * c + (r + 2) % 4]) ^ gmul('h09, t[4 * c + (r + 3) % 4]);
                res[127 - 8 * (4 * c + r) -: 8] = 8'(v);
            end
        end
        return res;
    endfunction

    // Scoreboard: record accepted states and retire completed outputs.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            first_seen = 0;
            prev_rise  = -1;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                first_seen = 0;
                outs++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(state_in, key_in, last_round));
                acc_q.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected no output", state_out);
            end else begin
                check("state_out", state_out, exp_q[0]);
                check("in_ready_during_out", 128'(in_ready), 128'd0);
                if (!first_seen) begin
                    first_seen = 1;
                    check("latency", 128'(cyc - acc_q[0]), 128'd5);
                    if (prev_rise >= 0) begin
                        checks++;
                        if (cyc - prev_rise < 6) begin
                            errors++;
                            $display("FAIL spacing: got %0d cycles expected at least 6",
                                     cyc - prev_rise);
                        end
                    end
                    prev_rise = cyc;
                end
            end
        end
    end

    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l);
        int n = 0;
        in_valid   = 1'b1;
        state_in   = s;
        key_in     = k;
        last_round = l;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: got out_valid=0 expected 1 within 20 cycles");
        end
    endtask

    task automatic run(input logic [127:0] s, input logic [127:0] k, input logic l,
                       output logic [127:0] res);
        send(s, k, l);
        wait_out();
        res = state_out;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] held;
        logic [31:0]  exp_col;
        int n;
        int outs0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        state_in = '0; key_in = '0; last_round = 1'b0;
        build_table();

        check("model_vec1", model(V1_IN, '0, 1'b1), V1_OUT);
        check("model_zero", model('0, '0, 1'b0), {16{8'h52}});
        check("model_ff_last", model('0, '1, 1'b1), {16{8'had}});

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_state_out", state_out, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(V1_IN, '0, 1'b1, res);
        check("vec1", res, V1_OUT);
        check("vec1_post_in_ready", 128'(in_ready), 128'd1);
        check("vec1_post_out_valid", 128'(out_valid), 128'd0);

        run('0, '0, 1'b0, res);
        check("zero_state", res, {16{8'h52}});
        run('0, '1, 1'b1, res);
        check("ff_key_last", res, {16{8'had}});

`ifdef AES_INV_MIXCOL_EN
        exp_col = 32'hdb135345;
`else
        exp_col = 32'h8e4da1bc;
`endif
        run('0, {32'hdc1ff3ee, 96'h0}, 1'b0, res);
        check("mixcol_col0", 128'(res[127:96]), 128'(exp_col));

        // Backpressure: output held, a competing input must be ignored.
        out_ready = 1'b0;
        send({$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(),
             $urandom(), $urandom()}, 1'($urandom()));
        wait_out();
        held = state_out;
        in_valid = 1'b1;
        state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", 128'(out_valid), 128'd1);
            check("stall_in_ready", 128'(in_ready), 128'd0);
            check("stall_state_out", state_out, held);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        check("release_out_valid", 128'(out_valid), 128'd0);
        check("release_in_ready", 128'(in_ready), 128'd1);

        // Reset in the middle of the column loop.
        in_valid = 1'b1; state_in = V1_IN; key_in = '1; last_round = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_state_out", state_out, '0);
        rst = 1'b0;
        run(V1_IN, '0, 1'b1, res);
        check("vec1_after_rst", res, V1_OUT);

        // Back-to-back random states with in_valid held high.
        outs0 = outs;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            state_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
            key_in     = {$urandom(), $urandom(), $urandom(), $urandom()};
            last_round = 1'($urandom_range(0, 1));
            n = 0;
            while (!in_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while (outs - outs0 < 8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_count", 128'(outs - outs0), 128'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
